exec_sequencer: RTL

- Multi-cycle control FSM for the core datapath.
- Sequences the cycle order fetch -> decode -> execute -> memory -> writeback and owns the architectural PC register.
- Issues the instruction- and data-memory request/ack handshakes and pulses the latch/write enables consumed by the decoder, execute stage and register file.
- Loads the execute stage's computed next PC at retirement and detects memory timeouts and misaligned control flow.

---
 rtl/exec_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer.
// It owns the architectural PC and drives the memory and latch-enable strobes.
module exec_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_8000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        illegal,
  input  logic        halt_insn,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        reg_we_dec,
  input  logic        alu_multicycle,
  input  logic        alu_done,
  output logic        op_latch,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  input  logic [31:0] nextpc,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic [1:0]  err_code,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      cur, nxt;
  logic [7:0]  wait_cnt;
  logic [1:0]  err_nxt;
  logic        retire;
  logic        timeout;
  logic        misaligned;
  logic        raw_imem_req, raw_ir_we, raw_op_latch;
  logic        raw_dmem_req, raw_dmem_we, raw_rf_we;

  // An ack on the last permitted cycle still wins over the timeout.
  assign timeout    = (wait_cnt == TMO_LAST);
  assign misaligned = (nextpc[1:0] != 2'b00);

  always_comb begin
    nxt          = cur;
    err_nxt      = err_code;
    retire       = 1'b0;
    raw_imem_req = 1'b0;
    raw_ir_we    = 1'b0;
    raw_op_latch = 1'b0;
    raw_dmem_req = 1'b0;
    raw_dmem_we  = 1'b0;
    raw_rf_we    = 1'b0;
    case (cur)
      S_FETCH: begin
        raw_imem_req = 1'b1;
        if (imem_ack) begin
          raw_ir_we = 1'b1;
          nxt       = S_DECODE;
        end else if (timeout) begin
          nxt     = S_ERROR;
          err_nxt = 2'd1;
        end
      end
      S_DECODE: begin
        raw_op_latch = 1'b1;
        if (illegal)        nxt = S_ERROR;
        else if (halt_insn) nxt = S_HALT;
        else                nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!alu_multicycle || alu_done)
          nxt = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        raw_dmem_req = 1'b1;
        raw_dmem_we  = is_store;
        if (dmem_ack) begin
          nxt = S_WB;
        end else if (timeout) begin
          nxt     = S_ERROR;
          err_nxt = 2'd2;
        end
      end
      S_WB: begin
        if (misaligned) begin
          nxt     = S_ERROR;
          err_nxt = 2'd3;
        end else begin
          raw_rf_we = reg_we_dec & ~is_store;
          retire    = 1'b1;
          nxt       = S_FETCH;
        end
      end
      default: nxt = cur;
    endcase
  end

  // Strobes are forced low the moment reset asserts, abandoning any request.
  assign imem_req = raw_imem_req & nrst;
  assign ir_we    = raw_ir_we    & nrst;
  assign op_latch = raw_op_latch & nrst;
  assign dmem_req = raw_dmem_req & nrst;
  assign dmem_we  = raw_dmem_we  & nrst;
  assign rf_we    = raw_rf_we    & nrst;
  assign state    = cur;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur          <= S_FETCH;
      pc           <= RESET_PC;
      retire_count <= 32'd0;
      err_code     <= 2'd0;
      wait_cnt     <= 8'd0;
    end else begin
      cur      <= nxt;
      err_code <= err_nxt;
      if (retire) begin
        pc           <= nextpc;
        retire_count <= retire_count + 32'd1;
      end
      if (nxt != cur)
        wait_cnt <= 8'd0;
      else if (cur == S_FETCH || cur == S_MEM)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule
